// File: rtl/uart_pkg.sv
// Shared constants and state types for the memory-mapped 8N1 UART.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned OS_W       = $clog2(OVERSAMPLE);

    localparam logic [1:0] ADDR_DIV  = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;
    localparam logic [1:0] ADDR_TXD  = 2'd2;
    localparam logic [1:0] ADDR_RXD  = 2'd3;

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_t;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: one-clk tick every max(divisor,1) clks.
module uart_baud_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [DIV_W-1:0] i_divisor,
    input  logic             i_restart,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_tick;

    // Divisor 0 and 1 both mean "tick every clk".
    assign w_tick = (i_divisor <= DIV_W'(1)) || (r_cnt == i_divisor - DIV_W'(1));
    assign o_tick = w_tick;

    // Count 0..divisor-1; a divisor write restarts the period.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_restart || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_top_design.sv
// Memory-mapped 8N1 UART: register file, TX FSM and RX FSM around a shared baud tick.
module uart_top_design
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  address,
    input  logic        write_enable,
    input  logic [31:0] write_data,
    input  logic        read_enable,
    output logic [7:0]  read_data,
    output logic        tx,
    input  logic        rx
);

    localparam logic [OS_W-1:0] TICK_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] TICK_MID  = OS_W'(OVERSAMPLE / 2 - 1);

    logic [DIV_W-1:0] r_divisor;
    logic [7:0]       r_tx_data;
    logic [7:0]       r_read_data;

    tx_state_t        r_tx_state;
    logic             r_tx;
    logic [7:0]       r_tx_shift;
    logic [OS_W-1:0]  r_tx_cnt;
    logic [2:0]       r_tx_bit;

    rx_state_t        r_rx_state;
    logic [1:0]       r_rx_sync;
    logic [7:0]       r_rx_shift;
    logic [OS_W-1:0]  r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_frame_err;

    logic             w_tick;
    logic             w_wr_div;
    logic             w_wr_txd;
    logic             w_launch;
    logic             w_rd_rxd;
    logic             w_tx_busy;
    logic             w_rx_s;

    assign w_wr_div  = write_enable && (address == ADDR_DIV);
    assign w_wr_txd  = write_enable && (address == ADDR_TXD);
    assign w_tx_busy = (r_tx_state != TxIdle);
    assign w_launch  = write_enable && (address == ADDR_CTRL) && write_data[0] && !w_tx_busy;
    assign w_rd_rxd  = read_enable && (address == ADDR_RXD);
    assign w_rx_s    = r_rx_sync[1];

    assign read_data = r_read_data;
    assign tx        = r_tx;

    uart_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud_gen (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_divisor (r_divisor),
        .i_restart (w_wr_div),
        .o_tick    (w_tick)
    );

    // Register file: write decode and registered read mux.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_divisor   <= '0;
            r_tx_data   <= '0;
            r_read_data <= '0;
        end else begin
            if (w_wr_div) r_divisor <= write_data[DIV_W-1:0];
            if (w_wr_txd) r_tx_data <= write_data[7:0];
            if (read_enable) begin
                case (address)
                    ADDR_DIV:  r_read_data <= r_divisor[7:0];
                    ADDR_CTRL: r_read_data <= {5'b0, r_frame_err, r_rx_valid, w_tx_busy};
                    ADDR_TXD:  r_read_data <= r_tx_data;
                    default:   r_read_data <= r_rx_data;
                endcase
            end
        end
    end

    // TX FSM: start bit begins on the first tick after launch; 16 ticks per bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TxIdle;
            r_tx       <= 1'b1;
            r_tx_shift <= '0;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
        end else begin
            case (r_tx_state)
                TxIdle: begin
                    if (w_launch) begin
                        r_tx_shift <= r_tx_data;
                        r_tx_cnt   <= '0;
                        r_tx_state <= TxStart;
                    end
                end
                TxStart: begin
                    if (w_tick) begin
                        // tx still high means the start bit has not begun yet
                        if (r_tx) begin
                            r_tx     <= 1'b0;
                            r_tx_cnt <= '0;
                        end else if (r_tx_cnt == TICK_LAST) begin
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_bit   <= '0;
                            r_tx_cnt   <= '0;
                            r_tx_state <= TxData;
                        end else begin
                            r_tx_cnt <= r_tx_cnt + OS_W'(1);
                        end
                    end
                end
                TxData: begin
                    if (w_tick) begin
                        if (r_tx_cnt == TICK_LAST) begin
                            r_tx_cnt <= '0;
                            if (r_tx_bit == 3'd7) begin
                                r_tx       <= 1'b1;
                                r_tx_state <= TxStop;
                            end else begin
                                r_tx       <= r_tx_shift[0];
                                r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                                r_tx_bit   <= r_tx_bit + 3'd1;
                            end
                        end else begin
                            r_tx_cnt <= r_tx_cnt + OS_W'(1);
                        end
                    end
                end
                TxStop: begin
                    if (w_tick) begin
                        if (r_tx_cnt == TICK_LAST) begin
                            r_tx_cnt   <= '0;
                            r_tx_state <= TxIdle;
                        end else begin
                            r_tx_cnt <= r_tx_cnt + OS_W'(1);
                        end
                    end
                end
                default: r_tx_state <= TxIdle;
            endcase
        end
    end

    // RX FSM with synchroniser; a completion in the same cycle as an RXD read keeps valid set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_sync   <= 2'b11;
            r_rx_state  <= RxIdle;
            r_rx_shift  <= '0;
            r_rx_cnt    <= '0;
            r_rx_bit    <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_sync <= {r_rx_sync[0], rx};
            if (w_rd_rxd) r_rx_valid <= 1'b0;
            case (r_rx_state)
                RxIdle: begin
                    if (!w_rx_s) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RxStart;
                    end
                end
                RxStart: begin
                    if (w_tick) begin
                        if (r_rx_cnt == TICK_MID) begin
                            r_rx_cnt   <= '0;
                            r_rx_bit   <= '0;
                            r_rx_state <= w_rx_s ? RxIdle : RxData;
                        end else begin
                            r_rx_cnt <= r_rx_cnt + OS_W'(1);
                        end
                    end
                end
                RxData: begin
                    if (w_tick) begin
                        if (r_rx_cnt == TICK_LAST) begin
                            r_rx_cnt   <= '0;
                            r_rx_shift <= {w_rx_s, r_rx_shift[7:1]};
                            r_rx_bit   <= r_rx_bit + 3'd1;
                            if (r_rx_bit == 3'd7) r_rx_state <= RxStop;
                        end else begin
                            r_rx_cnt <= r_rx_cnt + OS_W'(1);
                        end
                    end
                end
                RxStop: begin
                    if (w_tick) begin
                        if (r_rx_cnt == TICK_LAST) begin
                            r_rx_cnt   <= '0;
                            r_rx_state <= RxIdle;
                            if (w_rx_s) begin
                                r_rx_data   <= r_rx_shift;
                                r_rx_valid  <= 1'b1;
                                r_frame_err <= 1'b0;
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                        end else begin
                            r_rx_cnt <= r_rx_cnt + OS_W'(1);
                        end
                    end
                end
                default: r_rx_state <= RxIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_top_design.sv
// Scoreboard bench for uart_top_design: bus reads and TX frames are checked by monitors.
module tb_uart_top_design;

    localparam int BIT_CLKS  = 2080;   // 16 * divisor 130
    localparam int HALF_CLKS = 1040;

    logic        clk;
    logic        rst;
    logic [1:0]  address;
    logic        write_enable;
    logic [31:0] write_data;
    logic        read_enable;
    logic [7:0]  read_data;
    logic        tx;
    logic        rx;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] rd_exp[$];
    logic [1:0] rd_addr[$];
    logic [7:0] tx_exp[$];
    logic       rd_pend;

    uart_top_design #(
        .DIV_W (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .tx           (tx),
        .rx           (rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rd_pend <= read_enable;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address      = a;
        write_data   = d;
        write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [7:0] exp);
        address     = a;
        read_enable = 1'b1;
        rd_exp.push_back(exp);
        rd_addr.push_back(a);
        @(negedge clk);
        read_enable = 1'b0;
    endtask

    // Drive one frame on rx; a bad stop is held low just past mid-bit, then released.
    task automatic drive_rx(input logic [7:0] b, input logic good_stop);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        if (good_stop) begin
            rx = 1'b1;
            repeat (BIT_CLKS) @(negedge clk);
        end else begin
            rx = 1'b0;
            repeat (1200) @(negedge clk);
            rx = 1'b1;
            repeat (BIT_CLKS - 1200) @(negedge clk);
        end
    endtask

    // Read monitor: compare read_data on the negedge after each read strobe.
    initial begin : rd_mon
        logic [7:0] e;
        logic [1:0] a;
        forever begin
            @(negedge clk);
            if (rd_pend === 1'b1) begin
                if (rd_exp.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL read_unexpected: got 0x%0h, expected no read", read_data);
                end else begin
                    e = rd_exp.pop_front();
                    a = rd_addr.pop_front();
                    check($sformatf("read_addr%0d", a), {24'd0, read_data}, {24'd0, e});
                end
            end
        end
    end

    // TX monitor: on a falling tx, sample 10 mid-bit points and compare against the next frame.
    initial begin : tx_mon
        logic [9:0] obs;
        logic [7:0] e;
        logic       have;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                have = (tx_exp.size() != 0);
                e    = have ? tx_exp.pop_front() : 8'h00;
                if (!have) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL tx_unexpected_frame: got start bit, expected idle line");
                end
                repeat (HALF_CLKS - 1) @(negedge clk);
                obs[0] = tx;
                for (int i = 1; i < 10; i++) begin
                    repeat (BIT_CLKS) @(negedge clk);
                    obs[i] = tx;
                end
                if (have) check("tx_frame", {22'd0, obs}, {22'd0, 1'b1, e, 1'b0});
            end
        end
    end

    initial begin : watchdog
        #1500000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : stim
        rst          = 1'b1;
        address      = 2'd0;
        write_enable = 1'b0;
        write_data   = 32'd0;
        read_enable  = 1'b0;
        rx           = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_read_data", {24'd0, read_data}, 32'd0);
        rst = 1'b0;
        bus_read(2'd1, 8'h00);

        // Register access, reserved address ignored
        bus_write(2'd0, 32'd130);
        bus_write(2'd2, 32'h0000_0069);
        bus_read(2'd0, 8'h82);
        bus_read(2'd2, 8'h69);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd0, 8'h82);
        bus_read(2'd2, 8'h69);

        // TX 0x69 in parallel with RX 0x2D
        tx_exp.push_back(8'h69);
        bus_write(2'd1, 32'd1);
        fork
            begin
                repeat (3000) @(negedge clk);
                bus_read(2'd1, 8'h01);
            end
            drive_rx(8'h2D, 1'b1);
        join
        repeat (500) @(negedge clk);
        bus_read(2'd1, 8'h02);
        bus_read(2'd3, 8'h2D);
        bus_read(2'd1, 8'h00);

        // One-clk glitch in idle must not produce a frame
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (3000) @(negedge clk);
        bus_read(2'd1, 8'h00);

        // TX 0xA5 with mid-frame CTRL/TXD writes, in parallel with a bad-stop RX frame
        bus_write(2'd2, 32'h0000_00A5);
        tx_exp.push_back(8'hA5);
        fork
            begin
                bus_write(2'd1, 32'd1);
                repeat (5000) @(negedge clk);
                bus_write(2'd2, 32'h0000_003C);
                bus_write(2'd1, 32'd1);
                repeat (5000) @(negedge clk);
                bus_write(2'd1, 32'd1);
            end
            drive_rx(8'h55, 1'b0);
        join
        repeat (2000) @(negedge clk);
        bus_read(2'd1, 8'h04);
        bus_read(2'd2, 8'h3C);
        repeat (3000) @(negedge clk);

        check("tx_frames_pending", tx_exp.size(), 32'd0);
        check("reads_pending", rd_exp.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
